// File: rtl/key_onehot_scanner_pkg.sv
// Shared constants for the key one-hot scanner: FSM encoding, default
// debounce depth and the fixed-priority request pick.
package key_onehot_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } scan_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_CNT_W           = 4;
    localparam int NUM_KEYS                = 4;

    // Highest index wins: I3 > I2 > I1 > I0.
    function automatic logic [3:0] pick_highest(input logic [3:0] req);
        logic [3:0] pick;
        if (req[3]) begin
            pick = 4'b1000;
        end else if (req[2]) begin
            pick = 4'b0100;
        end else if (req[1]) begin
            pick = 4'b0010;
        end else if (req[0]) begin
            pick = 4'b0001;
        end else begin
            pick = 4'b0000;
        end
        return pick;
    endfunction

endpackage

// File: rtl/key_onehot_scanner_debounce_bit.sv
// One key line: 2-flop synchronizer, counter debounce and a registered
// single-cycle press pulse aligned with the debounced rising edge.
module debounce_bit
    import key_onehot_scanner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             deb_r;
    logic             rise_r;
    logic [CNT_W-1:0] cnt_r;
    logic             at_last_s;

    assign at_last_s = (cnt_r == CNT_LAST);

    // Synchronize, then accept a level only after DEBOUNCE_CYCLES mismatching samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            deb_r   <= 1'b0;
            rise_r  <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            if (sync2_r != deb_r) begin
                if (at_last_s) begin
                    deb_r  <= sync2_r;
                    cnt_r  <= CNT_ZERO;
                    rise_r <= sync2_r;
                end else begin
                    cnt_r  <= cnt_r + CNT_ONE;
                    rise_r <= 1'b0;
                end
            end else begin
                cnt_r  <= CNT_ZERO;
                rise_r <= 1'b0;
            end
        end
    end

    assign dout = deb_r;
    assign rise = rise_r;

endmodule

// File: rtl/key_onehot_scanner.sv
// Four debounced key lines feeding a capture/hold/release FSM that presents
// one prioritized request as a registered one-hot word until acknowledged.
module key_onehot_scanner
    import key_onehot_scanner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_in,
    output logic [3:0] onehot_out,
    output logic       valid,
    input  logic       ack
);

    logic [3:0]  deb_s;
    logic [3:0]  rise_s;
    scan_state_t state_r;
    logic [3:0]  onehot_r;
    logic        valid_r;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (key_in[i]),
            .dout  (deb_s[i]),
            .rise  (rise_s[i])
        );
    end

    // Capture one press, hold it until ack, then wait for every key to be released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            onehot_r <= 4'b0000;
            valid_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rise_s != 4'b0000) begin
                        onehot_r <= pick_highest(rise_s);
                        valid_r  <= 1'b1;
                        state_r  <= ST_HOLD;
                    end else begin
                        onehot_r <= 4'b0000;
                        valid_r  <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (ack) begin
                        onehot_r <= 4'b0000;
                        valid_r  <= 1'b0;
                        state_r  <= ST_RELEASE;
                    end else begin
                        onehot_r <= onehot_r;
                        valid_r  <= valid_r;
                    end
                end
                ST_RELEASE: begin
                    onehot_r <= 4'b0000;
                    valid_r  <= 1'b0;
                    if (deb_s == 4'b0000) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RELEASE;
                    end
                end
                default: begin
                    onehot_r <= 4'b0000;
                    valid_r  <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign onehot_out = onehot_r;
    assign valid      = valid_r;

endmodule
